// File: rtl/sprite_plotter.sv
// Sprite plotter: walks an SPR_W x SPR_H bitmap in row-major order and emits one
// clipped (x, y, colour, plot) frame-buffer write per unstalled cycle.
module sprite_plotter #(
    parameter int                     SPR_W    = 8,
    parameter int                     SPR_H    = 8,
    parameter int                     SCREEN_W = 160,
    parameter int                     SCREEN_H = 120,
    parameter logic [SPR_W*SPR_H-1:0] BITMAP0  = 64'h1818_3C3C_7E7E_FFDB,
    parameter logic [SPR_W*SPR_H-1:0] BITMAP1  = 64'hDBFF_7E3C_3C18_1800,
    parameter logic [2:0]             COLOUR0  = 3'b010,
    parameter logic [2:0]             COLOUR1  = 3'b100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       erase,
    input  logic       sprite_sel,
    input  logic [7:0] org_x,
    input  logic [6:0] org_y,
    input  logic       stall,
    output logic       busy,
    output logic       done,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot
);

    localparam int NPIX = SPR_W * SPR_H;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DRAW = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0]      LAST_COL   = 4'(SPR_W - 1);
    localparam logic [3:0]      LAST_ROW   = 4'(SPR_H - 1);
    localparam logic [7:0]      ROW_STRIDE = 8'(SPR_W);
    localparam logic [8:0]      X_LIMIT    = 9'(SCREEN_W);
    localparam logic [7:0]      Y_LIMIT    = 8'(SCREEN_H);
    localparam logic [NPIX-1:0] PIX_ONE    = NPIX'(1);

    logic [1:0] state_r;
    logic       erase_r;
    logic       sel_r;
    logic [7:0] org_x_r;
    logic [6:0] org_y_r;
    logic [3:0] row_r;
    logic [3:0] col_r;
    // Set once the last pixel has been issued; gives the final triplet its own cycle before DONE.
    logic       drain_r;

    logic [8:0]      x_sum_s;
    logic [7:0]      y_sum_s;
    logic [7:0]      bit_idx_s;
    logic [NPIX-1:0] map_s;
    logic [NPIX-1:0] mask_s;
    logic            opaque_s;
    logic [2:0]      colour_s;
    logic            visible_s;

    // Pixel address, bitmap lookup, clipping and colour for the current counters.
    always_comb begin
        x_sum_s   = {1'b0, org_x_r} + {5'b0_0000, col_r};
        y_sum_s   = {1'b0, org_y_r} + {4'b0000, row_r};
        bit_idx_s = ({4'b0000, row_r} * ROW_STRIDE) + {4'b0000, col_r};
        if (sel_r) begin
            map_s = BITMAP1;
        end else begin
            map_s = BITMAP0;
        end
        mask_s   = PIX_ONE << bit_idx_s;
        opaque_s = |(map_s & mask_s);
        if (erase_r) begin
            colour_s = 3'b000;
        end else if (sel_r) begin
            colour_s = COLOUR1;
        end else begin
            colour_s = COLOUR0;
        end
        visible_s = (x_sum_s < X_LIMIT) && (y_sum_s < Y_LIMIT) && (erase_r || opaque_s);
    end

    // Draw sequencer and registered plot-port outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            erase_r <= 1'b0;
            sel_r   <= 1'b0;
            org_x_r <= 8'd0;
            org_y_r <= 7'd0;
            row_r   <= 4'd0;
            col_r   <= 4'd0;
            drain_r <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            x       <= 8'd0;
            y       <= 7'd0;
            colour  <= 3'd0;
            plot    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    plot <= 1'b0;
                    busy <= 1'b0;
                    if (start && !stall) begin
                        erase_r <= erase;
                        sel_r   <= sprite_sel;
                        org_x_r <= org_x;
                        org_y_r <= org_y;
                        row_r   <= 4'd0;
                        col_r   <= 4'd0;
                        drain_r <= 1'b0;
                        busy    <= 1'b1;
                        state_r <= DRAW;
                    end
                end
                DRAW: begin
                    busy <= 1'b1;
                    if (stall) begin
                        plot <= 1'b0;
                    end else if (drain_r) begin
                        plot    <= 1'b0;
                        done    <= 1'b1;
                        drain_r <= 1'b0;
                        state_r <= DONE;
                    end else begin
                        x      <= x_sum_s[7:0];
                        y      <= y_sum_s[6:0];
                        colour <= colour_s;
                        plot   <= visible_s;
                        if (col_r == LAST_COL) begin
                            col_r <= 4'd0;
                            if (row_r == LAST_ROW) begin
                                drain_r <= 1'b1;
                            end else begin
                                row_r <= row_r + 4'd1;
                            end
                        end else begin
                            col_r <= col_r + 4'd1;
                        end
                    end
                end
                DONE: begin
                    plot    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    plot    <= 1'b0;
                    busy    <= 1'b0;
                    drain_r <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_plotter.sv
// Self-checking bench for sprite_plotter: table of draw requests, a pixel-write
// scoreboard fed from a reference model, plus reset-abort, stall and handshake cases.
module tb_sprite_plotter;

    localparam logic [63:0] BM0 = {64{1'b1}};
    localparam logic [63:0] BM1 = 64'h0000_0000_0000_0001;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } wr_t;

    typedef struct {
        logic       er;
        logic       sel;
        logic [7:0] ox;
        logic [6:0] oy;
        int         exp_wr;
        int         exp_done;
        int         stall_at;
        int         stall_len;
        int         ign_at;
        bit         ign_done;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       erase;
    logic       sprite_sel;
    logic [7:0] org_x;
    logic [6:0] org_y;
    logic       stall;
    logic       busy;
    logic       done;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;

    int   tests    = 0;
    int   failed   = 0;
    int   wr_count = 0;
    wr_t  exp_q[$];
    wr_t  mon_w;
    vec_t vecs[10];

    sprite_plotter #(
        .SPR_W(8), .SPR_H(8), .SCREEN_W(160), .SCREEN_H(120),
        .BITMAP0(BM0), .BITMAP1(BM1), .COLOUR0(3'b010), .COLOUR1(3'b100)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .erase(erase),
        .sprite_sel(sprite_sel), .org_x(org_x), .org_y(org_y), .stall(stall),
        .busy(busy), .done(done), .x(x), .y(y), .colour(colour), .plot(plot)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            failed++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    // Reference model: expected frame-buffer writes for the first npix pixels of a draw.
    function automatic void push_model(input logic er, input logic sel, input logic [7:0] ox,
                                       input logic [6:0] oy, input int npix);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                int   idx;
                int   xs;
                int   ys;
                logic opaque;
                wr_t  w;
                idx    = r * 8 + c;
                xs     = int'(ox) + c;
                ys     = int'(oy) + r;
                opaque = sel ? BM1[idx] : BM0[idx];
                if (idx < npix && xs < 160 && ys < 120 && (er || opaque)) begin
                    w.x = xs[7:0];
                    w.y = ys[6:0];
                    w.c = er ? 3'b000 : (sel ? 3'b100 : 3'b010);
                    exp_q.push_back(w);
                end
            end
        end
    endfunction

    // Scoreboard: every strobed write must be the next expected pixel.
    always @(negedge clk) begin
        if (plot === 1'b1) begin
            wr_count++;
            tests++;
            if (exp_q.size() == 0) begin
                failed++;
                $display("FAIL unexpected_write: got x=%0d y=%0d colour=%0d, required no write",
                         x, y, colour);
            end else begin
                mon_w = exp_q.pop_front();
                if ({x, y, colour} !== mon_w) begin
                    failed++;
                    $display("FAIL write_pixel: got x=%0d y=%0d colour=%0d, required x=%0d y=%0d colour=%0d",
                             x, y, colour, mon_w.x, mon_w.y, mon_w.c);
                end
            end
        end
    end

    task automatic run_draw(input vec_t v);
        int n;
        bit seen;
        int hx;
        int hy;
        push_model(v.er, v.sel, v.ox, v.oy, 64);
        wr_count = 0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        erase      = v.er;
        sprite_sel = v.sel;
        org_x      = v.ox;
        org_y      = v.oy;
        start      = 1'b1;
        hx   = int'(v.ox) + (v.stall_at - 2) % 8;
        hy   = int'(v.oy) + (v.stall_at - 2) / 8;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (n == 1) check("busy_after_accept", 32'(busy), 32'd1);
            if (v.stall_len > 0 && n > v.stall_at && n <= v.stall_at + v.stall_len) begin
                check("stall_plot", 32'(plot), 32'd0);
                check("stall_x", 32'(x), 32'(hx));
                check("stall_y", 32'(y), 32'(hy));
                check("stall_colour", 32'(colour), 32'd2);
            end
            if (done === 1'b1) begin
                seen = 1'b1;
                check("done_cycle", 32'(n), 32'(v.exp_done));
                check("busy_with_done", 32'(busy), 32'd1);
                check("plot_in_done", 32'(plot), 32'd0);
            end
            start      = (n == v.ign_at) || (seen && v.ign_done);
            erase      = ~v.er;
            sprite_sel = ~v.sel;
            org_x      = v.ox ^ 8'h5A;
            org_y      = v.oy ^ 7'h2B;
            stall      = (v.stall_len > 0 && n >= v.stall_at && n < v.stall_at + v.stall_len);
        end
        check("done_seen", 32'(seen), 32'd1);
        check("write_count", 32'(wr_count), 32'(v.exp_wr));
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int done_cnt;
        //          er    sel   org_x   org_y  wr  done stall len ign ign_done
        vecs[0] = '{1'b0, 1'b0, 8'd20,  7'd30,  64, 66, -1, 0, -1, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 8'd50,  7'd60,   1, 66, -1, 0, -1, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 8'd156, 7'd116, 16, 66, -1, 0, -1, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 8'd0,   7'd0,   64, 66, -1, 0, -1, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 8'd155, 7'd118, 10, 66, -1, 0, -1, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 8'd159, 7'd119,  1, 66, -1, 0, -1, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 8'd255, 7'd127,  0, 66, -1, 0, -1, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 8'd20,  7'd30,  64, 71, 13, 5, -1, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 8'd40,  7'd10,   1, 66, -1, 0, 10, 1'b1};
        vecs[9] = '{1'b0, 1'b0, 8'd100, 7'd50,  64, 66, -1, 0, -1, 1'b0};

        reset = 1'b1; start = 1'b0; erase = 1'b0; sprite_sel = 1'b0;
        org_x = 8'd0; org_y = 7'd0; stall = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_x", 32'(x), 32'd0);
        check("reset_y", 32'(y), 32'd0);
        check("reset_colour", 32'(colour), 32'd0);
        check("reset_plot", 32'(plot), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        reset = 1'b0;

        // Reset asserted while pixel 10 sits in the counters: pixels 0..9 only.
        push_model(1'b0, 1'b0, 8'd20, 7'd30, 10);
        wr_count = 0;
        @(negedge clk);
        org_x = 8'd20; org_y = 7'd30; start = 1'b1;
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1 reset = 1'b1;
        #1;
        check("abort_x", 32'(x), 32'd0);
        check("abort_y", 32'(y), 32'd0);
        check("abort_colour", 32'(colour), 32'd0);
        check("abort_plot", 32'(plot), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        done_cnt = 0;
        repeat (80) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_writes", 32'(wr_count), 32'd10);
        check("abort_queue", 32'(exp_q.size()), 32'd0);
        exp_q.delete();

        for (int i = 0; i < 10; i++) begin
            run_draw(vecs[i]);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
